// File: rtl/bidir_bus_arbiter.sv
// Ownership arbiter for a shared bidirectional data line driven by two tri-state ports.
// Issues mutually exclusive grants/enables with a fixed turnaround gap, round-robin ties and a hold timeout.
module bidir_bus_arbiter #(
   parameter int unsigned TURN_CYCLES = 2,
   parameter int unsigned MAX_HOLD    = 64,
   parameter int unsigned HOLD_W      = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic locked,
   input  logic req1,
   input  logic req2,
   output logic gnt1,
   output logic gnt2,
   output logic oe1,
   output logic oe2,
   output logic bus_busy,
   output logic timeout
);

   typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, TURN} state_t;

   localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
   localparam logic [3:0]        TURN_LAST  = 4'(TURN_CYCLES - 1);

   state_t            state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [3:0]        turn_cnt, turn_nxt;
   logic              last_is_side2, last_is_side2_nxt;
   logic              timeout_nxt;
   logic              win1, win2;
   logic              own_req, other_req;

   // Tie goes to the side that did not own the bus last.
   assign win1 = locked && req1 && (!req2 || last_is_side2);
   assign win2 = locked && req2 && (!req1 || !last_is_side2);

   assign own_req   = (state == GRANT1) ? req1 : req2;
   assign other_req = (state == GRANT1) ? req2 : req1;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt         = state;
      hold_nxt          = hold_cnt;
      turn_nxt          = turn_cnt;
      last_is_side2_nxt = last_is_side2;
      timeout_nxt       = 1'b0;

      case (state)
         IDLE: begin
            hold_nxt = '0;
            if (win1)      state_nxt = GRANT1;
            else if (win2) state_nxt = GRANT2;
         end

         GRANT1, GRANT2: begin
            if (!own_req || !locked ||
                (TIMEOUT_EN && (hold_cnt == HOLD_LAST) && other_req)) begin
               state_nxt         = TURN;
               turn_nxt          = '0;
               hold_nxt          = '0;
               last_is_side2_nxt = (state == GRANT2);
               // Only a preemption of a still-requesting owner on a locked clock counts as a timeout.
               timeout_nxt       = own_req && locked;
            end else if (hold_cnt != HOLD_SAT) begin
               hold_nxt = hold_cnt + HOLD_ONE;
            end
         end

         TURN: begin
            if (turn_cnt == TURN_LAST) begin
               if (win1)      state_nxt = GRANT1;
               else if (win2) state_nxt = GRANT2;
               else           state_nxt = IDLE;
            end else begin
               turn_nxt = turn_cnt + 4'd1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         turn_cnt      <= '0;
         last_is_side2 <= 1'b1;
         gnt1          <= 1'b0;
         gnt2          <= 1'b0;
         oe1           <= 1'b0;
         oe2           <= 1'b0;
         bus_busy      <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         state         <= state_nxt;
         hold_cnt      <= hold_nxt;
         turn_cnt      <= turn_nxt;
         last_is_side2 <= last_is_side2_nxt;
         // Enables get their own flops so they can be packed next to the IOBUFs.
         gnt1          <= (state_nxt == GRANT1);
         gnt2          <= (state_nxt == GRANT2);
         oe1           <= (state_nxt == GRANT1);
         oe2           <= (state_nxt == GRANT2);
         bus_busy      <= (state_nxt != IDLE);
         timeout       <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_bidir_bus_arbiter.sv
// Directed self-checking bench for bidir_bus_arbiter: default instance (MAX_HOLD=64)
// plus a MAX_HOLD=0 instance for the no-timeout case.
module tb_bidir_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic locked, req1, req2;
   logic gnt1, gnt2, oe1, oe2, bus_busy, timeout;
   logic b_locked, b_req1, b_req2;
   logic b_gnt1, b_gnt2, b_oe1, b_oe2, b_bus_busy, b_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bidir_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(64), .HOLD_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .locked(locked), .req1(req1), .req2(req2),
      .gnt1(gnt1), .gnt2(gnt2), .oe1(oe1), .oe2(oe2),
      .bus_busy(bus_busy), .timeout(timeout)
   );

   bidir_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(0), .HOLD_W(8)) dut_nohold (
      .clk(clk), .rst_n(rst_n), .locked(b_locked), .req1(b_req1), .req2(b_req2),
      .gnt1(b_gnt1), .gnt2(b_gnt2), .oe1(b_oe1), .oe2(b_oe2),
      .bus_busy(b_bus_busy), .timeout(b_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Structural invariants checked on every falling edge for the whole run.
   always @(negedge clk) begin
      check("oe_mutex",     {31'd0, oe1 & oe2},         32'd0);
      check("gnt_mutex",    {31'd0, gnt1 & gnt2},       32'd0);
      check("oe1_eq_gnt1",  {31'd0, oe1},               {31'd0, gnt1});
      check("oe2_eq_gnt2",  {31'd0, oe2},               {31'd0, gnt2});
      check("b_oe_mutex",   {31'd0, b_oe1 & b_oe2},     32'd0);
      check("b_oe1_eq",     {31'd0, b_oe1},             {31'd0, b_gnt1});
   end

   initial begin
      rst_n = 1'b0; locked = 1'b0; req1 = 1'b0; req2 = 1'b0;
      b_locked = 1'b0; b_req1 = 1'b0; b_req2 = 1'b0;
      tick(2);
      check("rst_gnt1", {31'd0, gnt1}, 32'd0);
      check("rst_gnt2", {31'd0, gnt2}, 32'd0);
      check("rst_oe1",  {31'd0, oe1},  32'd0);
      check("rst_busy", {31'd0, bus_busy}, 32'd0);
      check("rst_tmo",  {31'd0, timeout},  32'd0);

      // Single requester: 1-cycle grant latency, 2-cycle turnaround then idle.
      rst_n = 1'b1; locked = 1'b1;
      tick(3);
      req1 = 1'b1;
      tick();
      check("t1_gnt1", {31'd0, gnt1}, 32'd1);
      check("t1_oe1",  {31'd0, oe1},  32'd1);
      check("t1_busy", {31'd0, bus_busy}, 32'd1);
      tick(14);
      check("t1_hold", {31'd0, gnt1}, 32'd1);
      req1 = 1'b0;
      tick();
      check("t1_rel_oe1",  {31'd0, oe1}, 32'd0);
      check("t1_turn1",    {31'd0, bus_busy}, 32'd1);
      tick();
      check("t1_turn2",    {31'd0, bus_busy}, 32'd1);
      tick();
      check("t1_idle",     {31'd0, bus_busy}, 32'd0);

      // Simultaneous requests after reset: side 1 first, then side 2 after the gap.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req1 = 1'b1; req2 = 1'b1;
      tick();
      check("t2_gnt1", {31'd0, gnt1}, 32'd1);
      check("t2_gnt2", {31'd0, gnt2}, 32'd0);
      tick(3);
      req1 = 1'b0;
      tick();
      check("t2_gap1", {30'd0, gnt1, gnt2}, 32'd0);
      tick();
      check("t2_gap2", {30'd0, gnt1, gnt2}, 32'd0);
      tick();
      check("t2_gnt2_after_gap", {30'd0, gnt1, gnt2}, 32'd1);
      req2 = 1'b0;
      tick(3);
      check("t2_idle", {31'd0, bus_busy}, 32'd0);

      // Timeout: side 1 holds while side 2 waits; preempted after 64 owned cycles.
      req1 = 1'b1;
      tick();
      check("t3_gnt1", {31'd0, gnt1}, 32'd1);
      req2 = 1'b1;
      tick(63);
      check("t3_still_owner", {31'd0, gnt1}, 32'd1);
      check("t3_no_tmo_yet",  {31'd0, timeout}, 32'd0);
      tick();
      check("t3_preempt_gnt1", {31'd0, gnt1}, 32'd0);
      check("t3_tmo_pulse",    {31'd0, timeout}, 32'd1);
      tick();
      check("t3_tmo_one_cycle", {31'd0, timeout}, 32'd0);
      check("t3_gap_gnt2",      {31'd0, gnt2}, 32'd0);
      tick();
      check("t3_gnt2", {31'd0, gnt2}, 32'd1);
      tick(5);
      req2 = 1'b0;
      tick();
      check("t3_rel2_gnt2", {31'd0, gnt2}, 32'd0);
      check("t3_rel2_tmo",  {31'd0, timeout}, 32'd0);
      tick();
      check("t3_regrant_gap", {31'd0, gnt1}, 32'd0);
      tick();
      check("t3_regrant1", {31'd0, gnt1}, 32'd1);
      req1 = 1'b0;
      tick(3);
      check("t3_idle", {31'd0, bus_busy}, 32'd0);

      // Lock gating: no grant while unlocked; forced release without timeout.
      locked = 1'b0; req1 = 1'b1;
      tick(3);
      check("t4_nolock_gnt1", {31'd0, gnt1}, 32'd0);
      check("t4_nolock_busy", {31'd0, bus_busy}, 32'd0);
      locked = 1'b1;
      tick();
      check("t4_lock_gnt1", {31'd0, gnt1}, 32'd1);
      tick(2);
      locked = 1'b0;
      tick();
      check("t4_forced_gnt1", {31'd0, gnt1}, 32'd0);
      check("t4_forced_tmo",  {31'd0, timeout}, 32'd0);
      check("t4_forced_busy", {31'd0, bus_busy}, 32'd1);
      tick(2);
      check("t4_stay_idle_gnt", {30'd0, gnt1, gnt2}, 32'd0);
      check("t4_stay_idle_busy", {31'd0, bus_busy}, 32'd0);
      tick(2);
      check("t4_no_regrant", {31'd0, gnt1}, 32'd0);
      req1 = 1'b0; locked = 1'b1;
      tick(2);

      // Asynchronous reset in the middle of a GRANT2 tenure.
      req2 = 1'b1;
      tick();
      check("t5_gnt2", {31'd0, gnt2}, 32'd1);
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_gnt2", {31'd0, gnt2}, 32'd0);
      check("t5_async_oe2",  {31'd0, oe2},  32'd0);
      rst_n = 1'b1;
      tick();
      check("t5_regrant2", {31'd0, gnt2}, 32'd1);
      req2 = 1'b0;
      tick(3);

      // MAX_HOLD=0: side 1 keeps the bus forever while both request.
      b_locked = 1'b1; b_req1 = 1'b1; b_req2 = 1'b1;
      tick();
      check("t6_gnt1", {31'd0, b_gnt1}, 32'd1);
      for (int i = 0; i < 100; i++) begin
         tick();
         check("t6_keep_gnt1", {31'd0, b_gnt1}, 32'd1);
         check("t6_no_tmo",    {31'd0, b_timeout}, 32'd0);
      end
      check("t6_gnt2", {31'd0, b_gnt2}, 32'd0);
      b_req1 = 1'b0; b_req2 = 1'b0;
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
